switch_out_arbiter: RTL and testbench
=====================================

Name: switch_out_arbiter

Overview:
- Egress scheduler of the 4-port switch. Sits directly downstream of the per-port input FIFOs and consumes their head-of-line packets.
- Each output port has a round-robin arbiter that picks among inputs whose head packet targets that port.
- Multicast: one head packet is delivered to every port in its target mask, possibly over several cycles. The input FIFO is popped only after the last copy is granted.
- Outputs are registered with a valid/ready handshake toward the port transmit logic.

Parameters:
- NUM_PORTS, 4, number of input and output ports (arbiter logic requires a power of two).
- DATA_W, 8, packet payload width.
- TYPE_W, 2, packet type field width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NUM_PORTS  input FIFO i is non-empty; show-ahead head is presented.
- in_target  in  NUM_PORTS*NUM_PORTS  head target mask per input; bits [i*N +: N].
- in_data  in  NUM_PORTS*DATA_W  head payload per input.
- in_type  in  NUM_PORTS*TYPE_W  head type per input.
- in_pop  out  NUM_PORTS  pop pulse to input FIFO i (combinational, same cycle as the final grant).
- out_valid  out  NUM_PORTS  output register j holds a packet.
- out_ready  in  NUM_PORTS  port j transmit logic accepts the packet.
- out_data  out  NUM_PORTS*DATA_W  payload per output.
- out_src  out  NUM_PORTS*2  source input index per output (width log2(NUM_PORTS)).
- out_type  out  NUM_PORTS*TYPE_W  type per output.
- stat_grants  out  NUM_PORTS*16  per-output grant counters (see Optional Feature).
- stat_zero_drops  out  16  count of zero-target packets discarded (see Optional Feature).

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - out_valid=0; out_data, out_src and out_type = 0.
  - All loaded flags and pending masks = 0.
  - All RR pointers = 0; counters = 0.
  - in_pop=0 while rst is high.
- Reset mid-operation discards partially delivered multicasts; the FIFO head is not popped.
- Per-input state: loaded[i] (1 bit), pend[i] (NUM_PORTS bits).
  - Effective mask: eff[i] = loaded[i] ? pend[i] : (in_valid[i] ? in_target[i] : 0).
  - The first grant on a fresh head uses in_target directly, so there is no load bubble.
- Per-output j:
  - free[j] = !out_valid[j] | out_ready[j].
  - req_j[i] = eff[i][j].
  - If free[j] and req_j is non-zero: grant the first requesting i at or after ptr[j] (wrapping). Then:
    - load out_data[j], out_src[j], out_type[j] from input i;
    - set out_valid[j]=1 next cycle;
    - set ptr[j] = (i+1) mod NUM_PORTS.
  - If free[j] with no request: out_valid[j] goes to 0 on the out_ready handshake.
  - If not free: hold all output fields stable; ptr unchanged.
- Outputs arbitrate independently. One input may be granted by several outputs in the same cycle.
- Input update each cycle, with g[i] = OR of this cycle's grants for input i:
  - rem = eff[i] & ~g[i].
  - If eff[i]!=0 and rem==0 and g[i]!=0: in_pop[i]=1; next cycle loaded=0, pend=0.
  - Else if eff[i]!=0 and g[i]!=0: loaded=1, pend=rem.
  - Else hold.
- Zero target: in_valid[i] & !loaded[i] & in_target[i]==0 gives in_pop[i]=1 that cycle, no output, and the drop counter increments.
- Latency: head visible at cycle c with out port free gives out_valid at c+1.
- Throughput: one packet per output per cycle under full out_ready.
- Fairness: with all N inputs contending for one output, each input is granted once per N grants.
- in_valid deasserting while loaded=1 is a protocol violation: pend is held, no pop is issued, and a simulation assertion fires.

Optional Feature:
- Macro SWITCH_ARB_STATS_EN.
- Defined:
  - stat_grants[j] increments on every grant by output j.
  - stat_zero_drops increments on every zero-target discard.
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops exist. Datapath behaviour is identical.

Decomposition:
- Package switch_arb_pkg:
  - NUM_PORTS_C, PORT_IDX_W, DATA_W_C, TYPE_W_C;
  - typedef arb_pkt_t {src, type, data};
  - typedef port_mask_t.
- Sub-module rr_arbiter: N-bit request and pointer in, one-hot grant plus encoded index out. Purely combinational search; the pointer register stays in the parent. One instance per output port.

Test Plan:
- Unicast: in_valid[0]=1, target 4'b0100, data 8'hA5, type 2, all ready → in_pop[0] at c; out_valid[2] at c+1 with data A5, src 0, type 2; no other out_valid.
- Multicast: input 1, target 4'b1011, data 8'h3C → out_valid[0], [1], [3] all at c+1 with data 3C, src 1; single in_pop[1] pulse.
- Contention: all 4 inputs target 4'b0001 continuously, out_ready[0]=1 → grant order on port 0 is src 0,1,2,3,0,... one per cycle.
- Backpressure: out_valid[1] stuck with out_ready[1]=0; input 2 sends target 4'b0011 → port 0 is delivered at c+1, pend[2]=4'b0010, no pop; out_data[1] stays stable 5 cycles. Raising out_ready[1] gives the port 1 grant and in_pop[2] in the same cycle.
- Zero target: input 3 head has target 4'b0000 → in_pop[3] at c, no out_valid; stat_zero_drops=1 with SWITCH_ARB_STATS_EN, 0 without.
- Reset mid-multicast: rst during the backpressure scenario → all out_valid=0, no pop, ptr=0. The next multicast after reset delivers all copies normally.

Source files
------------

// File: rtl/switch_arb_pkg.sv
// Shared types and sizing for the switch egress arbiter.
package switch_arb_pkg;

  localparam int NUM_PORTS_C = 4;
  localparam int PORT_IDX_W  = $clog2(NUM_PORTS_C);
  localparam int DATA_W_C    = 8;
  localparam int TYPE_W_C    = 2;

  typedef logic [NUM_PORTS_C-1:0] port_mask_t;

  typedef struct packed {
    logic [PORT_IDX_W-1:0] src;
    logic [TYPE_W_C-1:0]   pkt_type;
    logic [DATA_W_C-1:0]   data;
  } arb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
// The pointer register lives in the parent.
module rr_arbiter
  import switch_arb_pkg::*;
(
  input  logic [NUM_PORTS_C-1:0] req,
  input  logic [PORT_IDX_W-1:0]  ptr,
  output logic [NUM_PORTS_C-1:0] gnt,
  output logic [PORT_IDX_W-1:0]  gnt_idx,
  output logic                   gnt_any
);

  // Scan from ptr upward; index arithmetic wraps because the port count is a power of two.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_PORTS_C; k++) begin
      if (!gnt_any && req[ptr + PORT_IDX_W'(k)]) begin
        gnt[ptr + PORT_IDX_W'(k)] = 1'b1;
        gnt_idx                   = ptr + PORT_IDX_W'(k);
        gnt_any                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Egress scheduler: per-output round-robin arbitration over the input FIFO
// heads, with multicast delivered over as many cycles as the outputs allow.
// A head is popped only once its last copy is granted.
// Optional macro SWITCH_ARB_STATS_EN adds saturating grant / zero-drop counters;
// without it the stat ports read 0.
module switch_out_arbiter
  import switch_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_C,
  parameter int DATA_W    = DATA_W_C,
  parameter int TYPE_W    = TYPE_W_C
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  in_target,
  input  logic [NUM_PORTS*DATA_W-1:0]     in_data,
  input  logic [NUM_PORTS*TYPE_W-1:0]     in_type,
  output logic [NUM_PORTS-1:0]            in_pop,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS*DATA_W-1:0]     out_data,
  output logic [NUM_PORTS*PORT_IDX_W-1:0] out_src,
  output logic [NUM_PORTS*TYPE_W-1:0]     out_type,
  output logic [NUM_PORTS*16-1:0]         stat_grants,
  output logic [15:0]                     stat_zero_drops
);

  port_mask_t            loaded;
  port_mask_t            pend    [NUM_PORTS];
  port_mask_t            eff     [NUM_PORTS];
  port_mask_t            req     [NUM_PORTS];
  port_mask_t            gnt     [NUM_PORTS];
  port_mask_t            g_in    [NUM_PORTS];
  logic [PORT_IDX_W-1:0] gnt_idx [NUM_PORTS];
  logic [PORT_IDX_W-1:0] ptr     [NUM_PORTS];
  arb_pkt_t              in_pkt  [NUM_PORTS];
  arb_pkt_t              out_pkt [NUM_PORTS];
  port_mask_t            gnt_any;
  port_mask_t            free;
  port_mask_t            take;
  port_mask_t            zero_drop;

  // Effective request mask per input; a fresh head requests with in_target directly.
  // A loaded head whose in_valid vanished requests nothing so pend is simply held.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (loaded[i]) eff[i] = in_valid[i] ? pend[i] : '0;
      else           eff[i] = in_valid[i] ? in_target[i*NUM_PORTS +: NUM_PORTS] : '0;
      zero_drop[i] = in_valid[i] && !loaded[i] && (in_target[i*NUM_PORTS +: NUM_PORTS] == '0);
      in_pkt[i]    = '{src: PORT_IDX_W'(i),
                       pkt_type: in_type[i*TYPE_W +: TYPE_W],
                       data: in_data[i*DATA_W +: DATA_W]};
    end
  end

  // Transpose input masks into per-output request vectors.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      free[j] = !out_valid[j] || out_ready[j];
      for (int i = 0; i < NUM_PORTS; i++) req[j][i] = eff[i][j];
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    rr_arbiter u_rr (
      .req     (req[j]),
      .ptr     (ptr[j]),
      .gnt     (gnt[j]),
      .gnt_idx (gnt_idx[j]),
      .gnt_any (gnt_any[j])
    );
  end

  // Collect this cycle's grants per input and decide pops.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) g_in[i] = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      take[j] = free[j] && gnt_any[j] && !rst;
      for (int i = 0; i < NUM_PORTS; i++) g_in[i][j] = take[j] && gnt[j][i];
    end
    for (int i = 0; i < NUM_PORTS; i++)
      in_pop[i] = !rst && (zero_drop[i] ||
                  ((eff[i] != '0) && (g_in[i] != '0) && ((eff[i] & ~g_in[i]) == '0)));
  end

  // Output registers and RR pointers; a busy output holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        out_pkt[j] <= '0;
        ptr[j]     <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (free[j]) begin
          if (gnt_any[j]) begin
            out_pkt[j]   <= in_pkt[gnt_idx[j]];
            out_valid[j] <= 1'b1;
            ptr[j]       <= gnt_idx[j] + 1'b1;
          end else begin
            out_valid[j] <= 1'b0;
          end
        end
      end
    end
  end

  // Per-input multicast progress: remember which copies are still owed.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded <= '0;
      for (int i = 0; i < NUM_PORTS; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((eff[i] != '0) && (g_in[i] != '0)) begin
          if ((eff[i] & ~g_in[i]) == '0) begin
            loaded[i] <= 1'b0;
            pend[i]   <= '0;
          end else begin
            loaded[i] <= 1'b1;
            pend[i]   <= eff[i] & ~g_in[i];
          end
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    assign out_data[j*DATA_W +: DATA_W]         = out_pkt[j].data;
    assign out_src[j*PORT_IDX_W +: PORT_IDX_W]  = out_pkt[j].src;
    assign out_type[j*TYPE_W +: TYPE_W]         = out_pkt[j].pkt_type;
  end

  // A head under multicast delivery must stay presented until its final copy.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk
    a_head_held: assert property (@(posedge clk) disable iff (rst) !(loaded[i] && !in_valid[i]));
  end

`ifdef SWITCH_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_PORTS];
  logic [15:0] drop_cnt;
  logic [16:0] drop_sum;

  always_comb drop_sum = {1'b0, drop_cnt} + 17'($countones(zero_drop));

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      for (int j = 0; j < NUM_PORTS; j++) grant_cnt[j] <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int j = 0; j < NUM_PORTS; j++)
        if (take[j] && grant_cnt[j] != 16'hFFFF) grant_cnt[j] <= grant_cnt[j] + 16'd1;
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_stat
    assign stat_grants[j*16 +: 16] = grant_cnt[j];
  end
  assign stat_zero_drops = drop_cnt;
`else
  assign stat_grants     = '0;
  assign stat_zero_drops = '0;
`endif

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Scoreboard bench for switch_out_arbiter: directed scenarios followed by
// randomized traffic, checked against a head-remaining-mask reference model.
module tb_switch_out_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [15:0] in_target;
  logic [31:0] in_data;
  logic [7:0]  in_type;
  logic [3:0]  in_pop;
  logic [3:0]  out_valid;
  logic [3:0]  rdy;
  logic [31:0] out_data;
  logic [7:0]  out_src;
  logic [7:0]  out_type;
  logic [63:0] stat_grants;
  logic [15:0] stat_zero_drops;

  switch_out_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_target(in_target),
    .in_data(in_data), .in_type(in_type), .in_pop(in_pop),
    .out_valid(out_valid), .out_ready(rdy), .out_data(out_data),
    .out_src(out_src), .out_type(out_type),
    .stat_grants(stat_grants), .stat_zero_drops(stat_zero_drops)
  );

  always #5 clk = ~clk;

  typedef struct { int tgt; int data; int typ; } tpkt_t;

  tpkt_t fifo [4][$];
  int    expq [4][$];
  int    rem [4];
  int    m_ptr [4];
  bit    m_ov [4];
  int    m_drops;
  int    m_grants [4];
  int    s_ptr [4];
  bit    s_ov [4];
  bit    s_push [4];
  int    s_pkt [4];
  bit    s_pop [4];
  bit    s_zero [4];
  int    s_gm [4];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int i, input int tgt, input int data, input int typ);
    tpkt_t p;
    p.tgt = tgt; p.data = data; p.typ = typ;
    if (fifo[i].size() == 0) rem[i] = tgt;
    fifo[i].push_back(p);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (fifo[i].size() > 0) begin
        in_valid[i]        = 1'b1;
        in_target[i*4 +: 4] = 4'(fifo[i][0].tgt);
        in_data[i*8 +: 8]   = 8'(fifo[i][0].data);
        in_type[i*2 +: 2]   = 2'(fifo[i][0].typ);
      end else begin
        in_valid[i]        = 1'b0;
        in_target[i*4 +: 4] = 4'h0;
        in_data[i*8 +: 8]   = 8'h00;
        in_type[i*2 +: 2]   = 2'h0;
      end
    end
  endtask

  // Reference: each output scans inputs from its pointer for a head still owing it a copy.
  task automatic model_eval();
    logic [3:0] exp_pop;
    exp_pop = 4'h0;
    for (int i = 0; i < 4; i++) begin s_gm[i] = 0; s_pop[i] = 0; s_zero[i] = 0; end
    if (rst) begin
      chk("pop_in_reset", in_pop, 4'h0);
      return;
    end
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("out_valid%0d", j), out_valid[j], m_ov[j]);
      s_ptr[j] = m_ptr[j]; s_ov[j] = m_ov[j]; s_push[j] = 0;
      if (!m_ov[j] || rdy[j]) begin
        s_ov[j] = 0;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_ptr[j] + k) % 4;
          if (!s_push[j] && fifo[idx].size() > 0 && rem[idx][j]) begin
            s_push[j] = 1;
            s_pkt[j]  = (idx << 10) | ((fifo[idx][0].typ & 3) << 8) | (fifo[idx][0].data & 255);
            s_ptr[j]  = (idx + 1) % 4;
            s_ov[j]   = 1;
            s_gm[idx] |= (1 << j);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      s_zero[i]  = fifo[i].size() > 0 && rem[i] == 0;
      s_pop[i]   = s_zero[i] || (s_gm[i] != 0 && (rem[i] & ~s_gm[i]) == 0);
      exp_pop[i] = s_pop[i];
    end
    chk("in_pop", in_pop, exp_pop);
  endtask

  task automatic model_commit();
    if (rst) begin
      for (int j = 0; j < 4; j++) begin
        m_ptr[j] = 0; m_ov[j] = 0; m_grants[j] = 0; expq[j].delete();
      end
      for (int i = 0; i < 4; i++) rem[i] = (fifo[i].size() > 0) ? fifo[i][0].tgt : 0;
      m_drops = 0;
      return;
    end
    for (int j = 0; j < 4; j++) begin
      m_ptr[j] = s_ptr[j];
      m_ov[j]  = s_ov[j];
      if (s_push[j]) begin
        expq[j].push_back(s_pkt[j]);
        m_grants[j]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (s_pop[i]) begin
        if (s_zero[i]) m_drops++;
        void'(fifo[i].pop_front());
        rem[i] = (fifo[i].size() > 0) ? fifo[i][0].tgt : 0;
      end else begin
        rem[i] = rem[i] & ~s_gm[i];
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // Monitor: every accepted output packet must be the oldest expected one for that port.
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < 4; j++) begin
        if (out_valid[j] && rdy[j]) begin
          if (expq[j].size() == 0) begin
            chk($sformatf("unexpected_pkt_port%0d", j), {out_src[j*2 +: 2], out_type[j*2 +: 2], out_data[j*8 +: 8]}, 64'hFFFF);
          end else begin
            int e;
            e = expq[j].pop_front();
            chk($sformatf("pkt_port%0d", j), {out_src[j*2 +: 2], out_type[j*2 +: 2], out_data[j*8 +: 8]}, 64'(e));
          end
        end
      end
    end
  end

  task automatic chk_stats(input string nm);
`ifdef SWITCH_ARB_STATS_EN
    chk({nm, "_drops"}, stat_zero_drops, 64'(m_drops));
    for (int j = 0; j < 4; j++) chk($sformatf("%s_grants%0d", nm, j), stat_grants[j*16 +: 16], 64'(m_grants[j]));
`else
    chk({nm, "_drops"}, stat_zero_drops, 64'h0);
    chk({nm, "_grants"}, stat_grants, 64'h0);
`endif
  endtask

  initial begin
    rst = 1'b1; rdy = 4'hF;
    in_valid = '0; in_target = '0; in_data = '0; in_type = '0;
    for (int i = 0; i < 4; i++) begin rem[i] = 0; m_ptr[i] = 0; m_ov[i] = 0; m_grants[i] = 0; end
    m_drops = 0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", out_src, 8'h0);
    chk("rst_out_type", out_type, 8'h0);
    chk_stats("rst");
    rst = 1'b0;

    // unicast
    push_pkt(0, 4'b0100, 8'hA5, 2);
    step();
    chk("uni_valid", out_valid, 4'b0100);
    chk("uni_data", out_data[23:16], 8'hA5);
    chk("uni_src", out_src[5:4], 2'd0);
    chk("uni_type", out_type[5:4], 2'd2);
    repeat (3) step();

    // multicast
    push_pkt(1, 4'b1011, 8'h3C, 1);
    step();
    chk("mc_valid", out_valid, 4'b1011);
    chk("mc_data0", out_data[7:0], 8'h3C);
    chk("mc_data1", out_data[15:8], 8'h3C);
    chk("mc_data3", out_data[31:24], 8'h3C);
    chk("mc_src3", out_src[7:6], 2'd1);
    repeat (3) step();

    // contention on port 0
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < 4; i++) push_pkt(i, 4'b0001, 8'h10 + n*4 + i, 0);
    repeat (16) step();

    // backpressure on port 1
    rdy = 4'b1101;
    push_pkt(0, 4'b0010, 8'h77, 3);
    step();
    push_pkt(2, 4'b0011, 8'h5A, 1);
    step();
    chk("bp_port0_valid", out_valid[0], 1'b1);
    chk("bp_port0_data", out_data[7:0], 8'h5A);
    repeat (5) begin
      step();
      chk("bp_hold_data", out_data[15:8], 8'h77);
      chk("bp_hold_valid", out_valid[1], 1'b1);
    end
    rdy = 4'hF;
    repeat (4) step();

    // reset in the middle of a partially delivered multicast
    rdy = 4'b1101;
    push_pkt(0, 4'b0010, 8'h66, 0);
    step();
    push_pkt(2, 4'b0011, 8'h99, 2);
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    chk("mid_rst_valid", out_valid, 4'h0);
    rst = 1'b0; rdy = 4'hF;
    step();
    chk("post_rst_valid", out_valid, 4'b0011);
    chk("post_rst_data0", out_data[7:0], 8'h99);
    chk("post_rst_data1", out_data[15:8], 8'h99);
    repeat (3) step();

    // zero target discard
    push_pkt(3, 4'b0000, 8'hEE, 0);
    step();
    chk("zero_no_valid", out_valid, 4'h0);
    step();
    chk_stats("zero");

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rdy = 4'($urandom);
      for (int i = 0; i < 4; i++)
        if (fifo[i].size() < 4 && $urandom_range(0, 2) == 0)
          push_pkt(i, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      step();
    end

    // drain
    rdy = 4'hF;
    repeat (40) step();
    for (int j = 0; j < 4; j++) chk($sformatf("drain_expq%0d", j), expq[j].size(), 0);
    chk("drain_valid", out_valid, 4'h0);
    chk_stats("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
